// File: rtl/fp_divide_seq.sv
// Sequential single-precision divider: Newton-Raphson reciprocal of the
// divisor mantissa, rescaled by the divisor exponent, then multiplied by A.
module fp_divide_seq #(
  parameter int XLEN       = 32,
  parameter int ITERATIONS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic            div_by_zero,
  output logic            overflow,
  output logic            underflow
);

  typedef enum logic [3:0] {
    IDLE, SEED_MUL, SEED_ADD, IT_MUL1, IT_SUB,
    IT_MUL2, SCALE, FINAL_MUL, DONE
  } state_e;

  localparam logic [31:0] SEED_K  = 32'h3FF0F0F1;
  localparam logic [31:0] SEED_C  = 32'h4034B4B5;
  localparam logic [31:0] TWO     = 32'h40000000;
  localparam logic [1:0]  IT_LAST = 2'(ITERATIONS - 1);

  function automatic logic [31:0] fmul(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [47:0] p;
    logic [7:0]  e;
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = x[30:23] + y[30:23] - 8'd127;
    if (p[47])
      fmul = {x[31] ^ y[31], e + 8'd1, 23'(p >> 24)};
    else
      fmul = {x[31] ^ y[31], e, 23'(p >> 23)};
  endfunction

  // 24 guard bits keep the aligned operand exact until the final truncation
  function automatic logic [31:0] fadd(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] hi, lo;
    logic [48:0] mh, ml, s;
    logic [7:0]  e, sh;
    if (x[30:0] >= y[30:0]) begin
      hi = x;
      lo = y;
    end else begin
      hi = y;
      lo = x;
    end
    e  = hi[30:23];
    sh = hi[30:23] - lo[30:23];
    mh = {2'b01, hi[22:0], 24'd0};
    ml = {2'b01, lo[22:0], 24'd0} >> sh;
    fadd = 32'd0;
    if (hi[31] == lo[31]) begin
      s = mh + ml;
      if (s[48]) begin
        s = s >> 1;
        e = e + 8'd1;
      end
      fadd = {hi[31], e, 23'(s >> 24)};
    end else begin
      s = mh - ml;
      if (s != 49'd0) begin
        for (int i = 0; i < 24; i++) begin
          if (!s[47]) begin
            s = s << 1;
            e = e - 8'd1;
          end
        end
        fadd = {hi[31], e, 23'(s >> 24)};
      end
    end
  endfunction

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] x_q, x_d, t_q, t_d, r_q, r_d;
  logic [1:0]  it_q, it_d;
  logic [31:0] quotient_q, quotient_d;
  logic        dbz_q, dbz_d, ovf_q, ovf_d, unf_q, unf_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] d_op;
  logic        q_s;
  logic [9:0]  sc_e, fm_e;
  logic [47:0] fm_p;

  assign d_op = {1'b0, 8'd126, b_q[22:0]};
  assign q_s  = a_q[31] ^ b_q[31];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    t_d         = t_q;
    r_d         = r_q;
    it_d        = it_q;
    quotient_d  = quotient_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;
    sc_e = {2'b00, x_q[30:23]} + 10'd126
         - {2'b00, b_q[30:23]};
    fm_p = 48'({1'b1, a_q[22:0]})
         * 48'({1'b1, r_q[22:0]});
    fm_e = {2'b00, a_q[30:23]} + {2'b00, r_q[30:23]}
         - 10'd127 + {9'd0, fm_p[47]};
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          it_d = 2'd0;
          if (b[30:23] == 8'd0 || a[30:23] == 8'd0)
            state_d = DONE;
          else
            state_d = SEED_MUL;
        end
      end
      SEED_MUL: begin
        t_d     = fmul(d_op, SEED_K);
        state_d = SEED_ADD;
      end
      SEED_ADD: begin
        x_d     = fadd(SEED_C, {~t_q[31], t_q[30:0]});
        state_d = IT_MUL1;
      end
      IT_MUL1: begin
        t_d     = fmul(d_op, x_q);
        state_d = IT_SUB;
      end
      IT_SUB: begin
        t_d     = fadd(TWO, {~t_q[31], t_q[30:0]});
        state_d = IT_MUL2;
      end
      IT_MUL2: begin
        x_d = fmul(x_q, t_q);
        if (it_q == IT_LAST) begin
          state_d = SCALE;
        end else begin
          it_d    = it_q + 2'd1;
          state_d = IT_MUL1;
        end
      end
      SCALE: begin
        if ($signed(sc_e) > 10'sd254) begin
          quotient_d  = {q_s, 8'hFF, 23'd0};
          ovf_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if ($signed(sc_e) < 10'sd1) begin
          quotient_d  = {q_s, 31'd0};
          unf_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          r_d     = {b_q[31], sc_e[7:0], x_q[22:0]};
          state_d = FINAL_MUL;
        end
      end
      FINAL_MUL: begin
        if ($signed(fm_e) > 10'sd254) begin
          quotient_d = {q_s, 8'hFF, 23'd0};
          ovf_d      = 1'b1;
        end else if ($signed(fm_e) < 10'sd1) begin
          quotient_d = {q_s, 31'd0};
          unf_d      = 1'b1;
        end else if (fm_p[47]) begin
          quotient_d = {q_s, fm_e[7:0], 23'(fm_p >> 24)};
        end else begin
          quotient_d = {q_s, fm_e[7:0], 23'(fm_p >> 23)};
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          // bypass entry: the result is decided from the operand classes
          if (b_q[30:23] == 8'd0) begin
            quotient_d = {q_s, 8'hFF, 23'd0};
            dbz_d      = 1'b1;
          end else begin
            quotient_d = {q_s, 31'd0};
          end
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      x_q         <= 32'd0;
      t_q         <= 32'd0;
      r_q         <= 32'd0;
      it_q        <= 2'd0;
      quotient_q  <= 32'd0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      t_q         <= t_d;
      r_q         <= r_d;
      it_q        <= it_d;
      quotient_q  <= quotient_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_fp_divide_seq.sv
// Scoreboard bench for fp_divide_seq: directed operands with
// hand-derived quotients, flags and latencies.
module tb_fp_divide_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] quotient;
  logic        div_by_zero, overflow, underflow;

  fp_divide_seq #(.XLEN(32), .ITERATIONS(3)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .div_by_zero(div_by_zero),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    int          tol;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input bit ok,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // monitor: compares each quotient on the cycle it is retired
  initial begin
    exp_t   e;
    longint dq;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1'b0, quotient, 32'd0);
        end else begin
          e  = sb.pop_front();
          dq = longint'(quotient) - longint'(e.q);
          if (dq < 0) dq = -dq;
          chk("quotient", dq <= longint'(e.tol), quotient, e.q);
          chk("flags",
              {div_by_zero, overflow, underflow} == e.fl,
              {29'd0, div_by_zero, overflow, underflow},
              {29'd0, e.fl});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drive_op(input logic [31:0] ta,
                          input logic [31:0] tb,
                          input bit push,
                          input logic [31:0] q,
                          input int tol,
                          input logic [2:0] fl);
    exp_t e;
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    if (push) begin
      e.q = q;
      e.tol = tol;
      e.fl = fl;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic await_out(input int lat);
    int n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", out_valid && (lat == 0 || n == lat),
        32'(n), 32'(lat));
  endtask

  task automatic await_retire();
    int n = 0;
    while (out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("retire", !out_valid, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] ta,
                        input logic [31:0] tb,
                        input logic [31:0] q,
                        input int tol,
                        input logic [2:0] fl,
                        input int lat);
    wait_ready();
    drive_op(ta, tb, 1'b1, q, tol, fl);
    await_out(lat);
    await_retire();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready == 1'b1, {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", quotient == 32'd0, quotient, 32'd0);
    chk("rst_flags", {div_by_zero, overflow, underflow} == 3'b000,
        {29'd0, div_by_zero, overflow, underflow}, 32'd0);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 2, 3'b000, 13);
    run_op(32'hC0C00000, 32'h40400000, 32'hC0000000, 2, 3'b000, 13);
    run_op(32'h3F800000, 32'h40800000, 32'h3E800000, 2, 3'b000, 13);
    run_op(32'h3F800000, 32'hC0800000, 32'hBE800000, 2, 3'b000, 13);
    run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 2, 3'b000, 13);
    run_op(32'h40A00000, 32'h00000000, 32'h7F800000, 0, 3'b100, 1);
    run_op(32'h00000000, 32'h80000000, 32'hFF800000, 0, 3'b100, 1);
    run_op(32'h80000000, 32'h40400000, 32'h80000000, 0, 3'b000, 1);
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 0, 3'b010, 13);
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 0, 3'b001, 0);

    // backpressure on a bypass result
    out_ready = 1'b0;
    wait_ready();
    drive_op(32'h40A00000, 32'h00000000, 1'b1,
             32'h7F800000, 0, 3'b100);
    await_out(1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, {31'd0, out_valid}, 32'd1);
      chk("hold_quotient", quotient == 32'h7F800000,
          quotient, 32'h7F800000);
      chk("hold_flags", {div_by_zero, overflow, underflow} == 3'b100,
          {29'd0, div_by_zero, overflow, underflow}, 32'd4);
      chk("hold_in_ready", !in_ready, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("retired_valid", !out_valid, {31'd0, out_valid}, 32'd0);
    chk("retired_in_ready", in_ready, {31'd0, in_ready}, 32'd1);
    drive_op(32'h40C00000, 32'h40400000, 1'b1,
             32'h40000000, 2, 3'b000);
    await_out(13);
    await_retire();

    // abort by reset mid-operation
    wait_ready();
    drive_op(32'h40C00000, 32'h40400000, 1'b0,
             32'd0, 0, 3'b000);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready", in_ready, {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", !out_valid, {31'd0, out_valid}, 32'd0);
    chk("abort_quotient", quotient == 32'd0, quotient, 32'd0);
    rst = 1'b0;
    run_op(32'h40C00000, 32'h40400000, 32'h40000000, 2, 3'b000, 13);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size() == 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
